// File: rtl/rr_grant_arb4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// Grant is carried internally as a 2-bit code plus enable, then decoded to a registered one-hot vector.
module rr_grant_arb4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       gnt_vld,
    output logic       gnt_new
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_next;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_next;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_next;
    logic             r_vld;
    logic             w_vld_next;
    logic             r_new;
    logic             w_new_next;
    logic [3:0]       r_gnt;
    logic [3:0]       w_gnt_next;

    logic [3:0]       w_owner_oh;
    logic             w_owner_req;
    logic [2:0]       w_pick_idle;
    logic [2:0]       w_pick_rot;
    logic [1:0]       w_rot_start;
    logic             w_hold_ok;

    // Returns {found, index}: first set bit of vec scanning start, start+1, ... mod 4.
    function automatic logic [2:0] pick(input logic [1:0] start, input logic [3:0] vec);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Owner one-hot (for masking) and the code+enable to one-hot grant decoder.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_decode
            assign w_owner_oh[gi] = (r_sel == 2'(gi));
            assign w_gnt_next[gi] = w_vld_next && (w_sel_next == 2'(gi));
        end
    endgenerate

    assign w_owner_req = |(req & w_owner_oh);
    assign w_rot_start = r_sel + 2'd1;
    assign w_pick_idle = pick(r_ptr, req);
    assign w_pick_rot  = pick(w_rot_start, req & ~w_owner_oh);
    assign w_hold_ok   = (r_hold_cnt < CNT_W'(MAX_HOLD));

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_hold_cnt_next = r_hold_cnt;
        w_sel_next      = r_sel;
        w_vld_next      = r_vld;
        w_new_next      = 1'b0;

        case (r_state)
            IDLE: begin
                w_vld_next = 1'b0;
                if (|req) begin
                    w_state_next    = GRANT;
                    w_sel_next      = w_pick_idle[1:0];
                    w_vld_next      = 1'b1;
                    w_new_next      = 1'b1;
                    w_hold_cnt_next = CNT_W'(1);
                end
            end
            GRANT: begin
                if (w_owner_req && w_hold_ok) begin
                    w_hold_cnt_next = r_hold_cnt + CNT_W'(1);
                end else begin
                    // Release or timeout: priority rotates past the current owner.
                    w_ptr_next = w_rot_start;
                    if (w_pick_rot[2]) begin
                        w_sel_next      = w_pick_rot[1:0];
                        w_new_next      = 1'b1;
                        w_hold_cnt_next = CNT_W'(1);
                    end else if (w_owner_req) begin
                        w_new_next      = 1'b1;
                        w_hold_cnt_next = CNT_W'(1);
                    end else begin
                        w_state_next    = IDLE;
                        w_vld_next      = 1'b0;
                        w_hold_cnt_next = '0;
                    end
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_vld_next      = 1'b0;
                w_hold_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= 2'b00;
            r_hold_cnt <= '0;
            r_sel      <= 2'b00;
            r_vld      <= 1'b0;
            r_new      <= 1'b0;
            r_gnt      <= 4'b0000;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_sel      <= w_sel_next;
            r_vld      <= w_vld_next;
            r_new      <= w_new_next;
            r_gnt      <= w_gnt_next;
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign gnt_vld = r_vld;
    assign gnt_new = r_new;

endmodule

// File: tb/tb_rr_grant_arb4.sv
// Directed bench for rr_grant_arb4: default build (MAX_HOLD=8) plus a MAX_HOLD=1 build.
module tb_rr_grant_arb4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       gnt_vld;
    logic       gnt_new;

    logic [3:0] req1;
    logic [3:0] gnt1;
    logic [1:0] sel1;
    logic       gnt_vld1;
    logic       gnt_new1;

    int errors = 0;
    int checks = 0;

    rr_grant_arb4 #(.MAX_HOLD(8), .CNT_W(8)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .gnt_vld (gnt_vld),
        .gnt_new (gnt_new)
    );

    rr_grant_arb4 #(.MAX_HOLD(1), .CNT_W(8)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .req     (req1),
        .gnt     (gnt1),
        .sel     (sel1),
        .gnt_vld (gnt_vld1),
        .gnt_new (gnt_new1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed as {gnt, sel, gnt_vld, gnt_new}.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got gnt=%b sel=%0d vld=%b new=%b, want gnt=%b sel=%0d vld=%b new=%b",
                   tag, obs[7:4], obs[3:2], obs[1], obs[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [7:0] e(input logic [3:0] g, input logic [1:0] s,
                                     input logic v, input logic n);
        return {g, s, v, n};
    endfunction

    function automatic logic [7:0] o0();
        return {gnt, sel, gnt_vld, gnt_new};
    endfunction

    function automatic logic [7:0] o1();
        return {gnt1, sel1, gnt_vld1, gnt_new1};
    endfunction

    initial begin
        logic [1:0] own;
        logic       nw;

        rst  = 1'b1;
        req  = 4'b0000;
        req1 = 4'b0000;
        step();
        step();
        chk("reset_main", o0(), e(4'b0000, 2'd0, 1'b0, 1'b0));
        chk("reset_mh1",  o1(), e(4'b0000, 2'd0, 1'b0, 1'b0));

        // All four requesting: 8 cycles each, starting at requester 0.
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 1; k <= 49; k++) begin
            step();
            own = 2'((k - 1) / 8);
            nw  = ((k - 1) % 8) == 0;
            chk($sformatf("rotate_c%0d", k), o0(), e(4'b0001 << own, own, 1'b1, nw));
        end

        // Reset mid-grant (owner 2) with everyone still requesting.
        rst = 1'b1;
        step();
        chk("rst_midgrant", o0(), e(4'b0000, 2'd0, 1'b0, 1'b0));
        rst = 1'b0;
        step();
        chk("post_rst_first", o0(), e(4'b0001, 2'd0, 1'b1, 1'b1));

        // Lone requester 2: re-granted at each timeout without dropping.
        rst = 1'b1;
        req = 4'b0100;
        step();
        chk("rst_before_solo", o0(), e(4'b0000, 2'd0, 1'b0, 1'b0));
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            nw = (k == 1) || (k == 9) || (k == 17);
            chk($sformatf("solo_c%0d", k), o0(), e(4'b0100, 2'd2, 1'b1, nw));
        end

        // Owner 1 releases while 3 and 0 request: 3 wins (scan starts at 2).
        rst = 1'b1;
        req = 4'b0000;
        step();
        rst = 1'b0;
        req = 4'b0010;
        step();
        chk("own1_grant", o0(), e(4'b0010, 2'd1, 1'b1, 1'b1));
        req = 4'b1001;
        step();
        chk("handoff_to3", o0(), e(4'b1000, 2'd3, 1'b1, 1'b1));
        req = 4'b0000;
        step();
        chk("drop_all", o0(), e(4'b0000, 2'd3, 1'b0, 1'b0));

        // One-cycle pulse from requester 1 (ptr is now 0 after the release).
        req = 4'b0010;
        step();
        chk("pulse_grant", o0(), e(4'b0010, 2'd1, 1'b1, 1'b1));
        req = 4'b0000;
        step();
        chk("pulse_release", o0(), e(4'b0000, 2'd1, 1'b0, 1'b0));
        step();
        chk("pulse_idle", o0(), e(4'b0000, 2'd1, 1'b0, 1'b0));

        // MAX_HOLD=1: two contenders alternate every cycle.
        req1 = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            step();
            own = (k % 2 == 1) ? 2'd0 : 2'd2;
            chk($sformatf("mh1_c%0d", k), o1(), e(4'b0001 << own, own, 1'b1, 1'b1));
        end
        req1 = 4'b0000;
        step();
        chk("mh1_release", o1(), e(4'b0000, 2'd2, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
